// File: rtl/bin_to_digit_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding a 4-digit display.
// Optional leading-zero blanking is enabled by defining BIN_TO_DIGIT_LZB_EN.
module bin_to_digit_conv #(
    parameter int IN_W    = 14,
    parameter int SAT_VAL = 9999
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [3:0]      digit_0,
    output logic [3:0]      digit_1,
    output logic [3:0]      digit_2,
    output logic [3:0]      digit_3
);

    localparam int SR_W  = IN_W + 16;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0]  SAT_V    = IN_W'(SAT_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [3:0]       BLANK    = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state_r;
    logic [SR_W-1:0]  sreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;
    logic [3:0]       digit_0_r, digit_1_r, digit_2_r, digit_3_r;

    logic [IN_W-1:0]  cap_s;
    logic             cap_ovf_s;
    logic [SR_W-1:0]  shifted_s;
    logic [15:0]      bcd_s;
    logic [15:0]      disp_s;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

    function automatic logic [15:0] adjust_bcd(input logic [15:0] bcd);
        return {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    endfunction

    // Saturate the incoming value and compute the next shift-register image
    always_comb begin
        cap_s     = value;
        cap_ovf_s = 1'b0;
        if (value > SAT_V) begin
            cap_s     = SAT_V;
            cap_ovf_s = 1'b1;
        end else begin
            cap_s     = value;
            cap_ovf_s = 1'b0;
        end
        shifted_s = {adjust_bcd(sreg_r[SR_W-1:IN_W]), sreg_r[IN_W-1:0]} << 1;
        bcd_s     = sreg_r[SR_W-1:IN_W];
    end

    // Display digit codes, with leading zeros optionally blanked (units digit never blanked)
    always_comb begin
        disp_s = bcd_s;
`ifdef BIN_TO_DIGIT_LZB_EN
        if (bcd_s[15:12] == 4'd0) begin
            disp_s[15:12] = BLANK;
            if (bcd_s[11:8] == 4'd0) begin
                disp_s[11:8] = BLANK;
                if (bcd_s[7:4] == 4'd0) begin
                    disp_s[7:4] = BLANK;
                end else begin
                    disp_s[7:4] = bcd_s[7:4];
                end
            end else begin
                disp_s[11:8] = bcd_s[11:8];
            end
        end else begin
            disp_s = bcd_s;
        end
`else
        disp_s = bcd_s;
`endif
    end

    // Conversion FSM with registered status and held digit outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sreg_r     <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            digit_0_r  <= BLANK;
            digit_1_r  <= BLANK;
            digit_2_r  <= BLANK;
            digit_3_r  <= BLANK;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sreg_r  <= {16'd0, cap_s};
                        ovf_r   <= cap_ovf_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_r <= shifted_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= LATCH;
                    end
                end
                LATCH: begin
                    digit_0_r  <= disp_s[15:12];
                    digit_1_r  <= disp_s[11:8];
                    digit_2_r  <= disp_s[7:4];
                    digit_3_r  <= disp_s[3:0];
                    overflow_r <= ovf_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign digit_0  = digit_0_r;
    assign digit_1  = digit_1_r;
    assign digit_2  = digit_2_r;
    assign digit_3  = digit_3_r;

endmodule
